// File: rtl/clint_axi_arb.sv
// rtl/clint_axi_arb.sv - two-master to one-slave AXI-lite arbiter with independent
// write/read paths, round-robin grant and a per-path watchdog that aborts with SLVERR.
module clint_axi_arb #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  // master 0
  input  logic [31:0] m0_awaddr,
  input  logic        m0_awvalid,
  output logic        m0_awready,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  input  logic        m0_wvalid,
  output logic        m0_wready,
  output logic [1:0]  m0_bresp,
  output logic        m0_bvalid,
  input  logic        m0_bready,
  input  logic [31:0] m0_araddr,
  input  logic        m0_arvalid,
  output logic        m0_arready,
  output logic [31:0] m0_rdata,
  output logic [1:0]  m0_rresp,
  output logic        m0_rvalid,
  input  logic        m0_rready,
  // master 1
  input  logic [31:0] m1_awaddr,
  input  logic        m1_awvalid,
  output logic        m1_awready,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  input  logic        m1_wvalid,
  output logic        m1_wready,
  output logic [1:0]  m1_bresp,
  output logic        m1_bvalid,
  input  logic        m1_bready,
  input  logic [31:0] m1_araddr,
  input  logic        m1_arvalid,
  output logic        m1_arready,
  output logic [31:0] m1_rdata,
  output logic [1:0]  m1_rresp,
  output logic        m1_rvalid,
  input  logic        m1_rready,
  // slave
  output logic [31:0] s_awaddr,
  output logic        s_awvalid,
  input  logic        s_awready,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  output logic        s_wvalid,
  input  logic        s_wready,
  output logic        s_wlast,
  input  logic [1:0]  s_bresp,
  input  logic        s_bvalid,
  output logic        s_bready,
  output logic [31:0] s_araddr,
  output logic        s_arvalid,
  input  logic        s_arready,
  input  logic [31:0] s_rdata,
  input  logic [1:0]  s_rresp,
  input  logic        s_rvalid,
  output logic        s_rready,
  input  logic        s_rlast
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT);
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

  // single-beat reads only, so the slave's last flag carries no information
  logic unused_rlast;
  assign unused_rlast = s_rlast;

  // ---------------- write path ----------------
  w_state_t      w_state;
  logic          w_gnt;
  logic          w_ptr;
  logic [CW-1:0] w_cnt;

  logic        g_awvalid, g_wvalid, g_bready;
  logic [31:0] g_awaddr, g_wdata;
  logic [3:0]  g_wstrb;

  assign g_awvalid = w_gnt ? m1_awvalid : m0_awvalid;
  assign g_awaddr  = w_gnt ? m1_awaddr  : m0_awaddr;
  assign g_wvalid  = w_gnt ? m1_wvalid  : m0_wvalid;
  assign g_wdata   = w_gnt ? m1_wdata   : m0_wdata;
  assign g_wstrb   = w_gnt ? m1_wstrb   : m0_wstrb;
  assign g_bready  = w_gnt ? m1_bready  : m0_bready;

  logic w_to, aw_act, wd_act, b_act;
  assign w_to   = (w_state != W_IDLE) && (w_cnt == TO_LIMIT);
  assign aw_act = (w_state == W_ADDR) && !w_to;
  assign wd_act = (w_state == W_DATA) && !w_to;
  assign b_act  = (w_state == W_RESP) && !w_to;

  assign s_awvalid = aw_act && g_awvalid;
  assign s_awaddr  = aw_act ? g_awaddr : '0;
  assign s_wvalid  = wd_act && g_wvalid;
  assign s_wdata   = wd_act ? g_wdata : '0;
  assign s_wstrb   = wd_act ? g_wstrb : '0;
  assign s_wlast   = wd_act;
  assign s_bready  = b_act && g_bready;

  logic       awready_g, wready_g, bvalid_g, done_w;
  logic [1:0] bresp_g;
  assign awready_g = aw_act && s_awready;
  assign wready_g  = wd_act && s_wready;
  // an expired watchdog answers the master itself with SLVERR
  assign bvalid_g  = w_to || (b_act && s_bvalid);
  assign bresp_g   = w_to ? SLVERR : (b_act ? s_bresp : 2'b00);
  assign done_w    = bvalid_g && g_bready;

  assign m0_awready = awready_g && !w_gnt;
  assign m1_awready = awready_g && w_gnt;
  assign m0_wready  = wready_g && !w_gnt;
  assign m1_wready  = wready_g && w_gnt;
  assign m0_bvalid  = bvalid_g && !w_gnt;
  assign m1_bvalid  = bvalid_g && w_gnt;
  assign m0_bresp   = w_gnt ? 2'b00 : bresp_g;
  assign m1_bresp   = w_gnt ? bresp_g : 2'b00;

  logic w_adv;
  assign w_adv = (s_awvalid && s_awready) || (s_wvalid && s_wready);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w_state <= W_IDLE;
      w_gnt   <= 1'b0;
      w_ptr   <= 1'b0;
      w_cnt   <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (m0_awvalid || m1_awvalid) begin
            w_gnt   <= (m0_awvalid && m1_awvalid) ? w_ptr : m1_awvalid;
            w_state <= W_ADDR;
            w_cnt   <= '0;
          end
        end
        default: begin
          if (done_w) begin
            w_state <= W_IDLE;
            w_ptr   <= ~w_gnt;
            w_cnt   <= '0;
          end else if (w_adv) begin
            w_state <= (w_state == W_ADDR) ? W_DATA : W_RESP;
            w_cnt   <= '0;
          end else if (!w_to) begin
            w_cnt <= w_cnt + CW'(1);
          end
        end
      endcase
    end
  end

  // ---------------- read path ----------------
  r_state_t      r_state;
  logic          r_gnt;
  logic          r_ptr;
  logic [CW-1:0] r_cnt;

  logic        g_arvalid, g_rready;
  logic [31:0] g_araddr;

  assign g_arvalid = r_gnt ? m1_arvalid : m0_arvalid;
  assign g_araddr  = r_gnt ? m1_araddr  : m0_araddr;
  assign g_rready  = r_gnt ? m1_rready  : m0_rready;

  logic r_to, ar_act, rd_act;
  assign r_to   = (r_state != R_IDLE) && (r_cnt == TO_LIMIT);
  assign ar_act = (r_state == R_ADDR) && !r_to;
  assign rd_act = (r_state == R_DATA) && !r_to;

  assign s_arvalid = ar_act && g_arvalid;
  assign s_araddr  = ar_act ? g_araddr : '0;
  assign s_rready  = rd_act && g_rready;

  logic        arready_g, rvalid_g, done_r;
  logic [1:0]  rresp_g;
  logic [31:0] rdata_g;
  assign arready_g = ar_act && s_arready;
  assign rvalid_g  = r_to || (rd_act && s_rvalid);
  assign rresp_g   = r_to ? SLVERR : (rd_act ? s_rresp : 2'b00);
  assign rdata_g   = rd_act ? s_rdata : '0;
  assign done_r    = rvalid_g && g_rready;

  assign m0_arready = arready_g && !r_gnt;
  assign m1_arready = arready_g && r_gnt;
  assign m0_rvalid  = rvalid_g && !r_gnt;
  assign m1_rvalid  = rvalid_g && r_gnt;
  assign m0_rresp   = r_gnt ? 2'b00 : rresp_g;
  assign m1_rresp   = r_gnt ? rresp_g : 2'b00;
  assign m0_rdata   = r_gnt ? '0 : rdata_g;
  assign m1_rdata   = r_gnt ? rdata_g : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= R_IDLE;
      r_gnt   <= 1'b0;
      r_ptr   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (m0_arvalid || m1_arvalid) begin
            r_gnt   <= (m0_arvalid && m1_arvalid) ? r_ptr : m1_arvalid;
            r_state <= R_ADDR;
            r_cnt   <= '0;
          end
        end
        default: begin
          if (done_r) begin
            r_state <= R_IDLE;
            r_ptr   <= ~r_gnt;
            r_cnt   <= '0;
          end else if (s_arvalid && s_arready) begin
            r_state <= R_DATA;
            r_cnt   <= '0;
          end else if (!r_to) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: doc/clint_axi_arb.md
CLINT_AXI_ARB -- requirements
Module: clint_axi_arb

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, cycles a granted transaction may wait on the slave before being aborted.
REQ-002 SHALL have port clk_i  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_i  input  1  asynchronous active-high reset.
REQ-004 SHALL have ports mN_awaddr (N=0,1) input 32 and s_awaddr output 32: write address.
REQ-005 SHALL have ports mN_awvalid input 1, mN_awready output 1, s_awvalid output 1, s_awready input 1: AW handshake.
REQ-006 SHALL have ports mN_wdata input 32 and s_wdata output 32: write data.
REQ-007 SHALL have ports mN_wstrb input 4 and s_wstrb output 4: byte strobes.
REQ-008 SHALL have ports mN_wvalid input 1, mN_wready output 1, s_wvalid output 1, s_wready input 1, s_wlast output 1: W handshake.
REQ-009 SHALL have ports mN_bresp output 2 and s_bresp input 2: write response.
REQ-010 SHALL have ports mN_bvalid output 1, mN_bready input 1, s_bvalid input 1, s_bready output 1: B handshake.
REQ-011 SHALL have ports mN_araddr input 32 and s_araddr output 32: read address.
REQ-012 SHALL have ports mN_arvalid input 1, mN_arready output 1, s_arvalid output 1, s_arready input 1: AR handshake.
REQ-013 SHALL have ports mN_rdata output 32, mN_rresp output 2, s_rdata input 32, s_rresp input 2: read data/response.
REQ-014 SHALL have ports mN_rvalid output 1, mN_rready input 1, s_rvalid input 1, s_rready output 1, s_rlast input 1 (ignored): R handshake.

Function
REQ-015 SHALL arbitrate write and read paths independently; one write and one read may be in flight concurrently, at most one of each.
REQ-016 Write FSM SHALL have states W_IDLE, W_ADDR, W_DATA, W_RESP; read FSM SHALL have states R_IDLE, R_ADDR, R_DATA.
REQ-017 In W_IDLE/R_IDLE SHALL grant on any mN_awvalid/mN_arvalid: single requester wins; both -> master indicated by round-robin pointer (separate pointer per path); grant registered, next state W_ADDR/R_ADDR.
REQ-018 SHALL forward channels only for the granted master; non-granted mN_awready, mN_wready, mN_arready, mN_bvalid, mN_rvalid SHALL be 0.
REQ-019 W_ADDR: s_awvalid=granted awvalid, s_awaddr=granted awaddr, granted awready=s_awready; on AW handshake -> W_DATA.
REQ-020 W_DATA: W channel forwarded, s_wlast=1 (single-beat only); on W handshake -> W_RESP.
REQ-021 W_RESP: granted bvalid/bresp from slave, s_bready=granted bready; on B handshake -> W_IDLE, write pointer set to the other master.
REQ-022 R_ADDR: AR forwarded; on AR handshake -> R_DATA; R_DATA: R forwarded; on R handshake -> R_IDLE, read pointer set to the other master.
REQ-023 Grant latency SHALL be exactly one cycle from first valid in IDLE to forwarded s_awvalid/s_arvalid.
REQ-024 Per-path watchdog counter SHALL reset on entering a non-IDLE state and increment each cycle without slave handshake; on reaching TIMEOUT in W_ADDR/W_DATA/W_RESP or R_ADDR/R_DATA the FSM SHALL drive granted bvalid/rvalid=1, bresp/rresp=2'b10 (SLVERR), rdata=0, deassert all s_* valid/ready, hold until master handshake, then IDLE and flip pointer.
REQ-025 Counter SHALL saturate at TIMEOUT; no wrap.
REQ-026 Master deasserting valid after grant SHALL NOT release grant; arbiter waits (subject to watchdog).
REQ-027 Request arriving on the same cycle a path returns to IDLE SHALL be evaluated in the following IDLE cycle with the updated pointer.

Reset
REQ-028 On rst_i=1 SHALL immediately force W_IDLE, R_IDLE, both pointers to master 0, watchdogs to 0.
REQ-029 During and after reset all mN_*ready, mN_*valid, s_*valid, s_*ready outputs SHALL be 0; data/resp outputs 0.
REQ-030 Reset mid-transaction SHALL abandon it with no response to either master.

Verification
REQ-031 m0 writes 0x0200_0000 data 0x1 alone -> s_awvalid one cycle after m0_awvalid, m0_bvalid with bresp 0, write pointer=1.
REQ-032 m0 and m1 both awvalid same cycle after reset -> m0 served first, m1 (0x0200_0004) next, no overlap on s_aw*.
REQ-033 m1 read 0x0200_C000 concurrent with m0 write 0x0200_0004 -> both complete, s_arvalid and s_awvalid overlap allowed.
REQ-034 Slave holds s_bready-path silent (s_bvalid=0) 16 cycles -> granted master gets bvalid, bresp=2'b10; next request served normally.
REQ-035 rst_i asserted in W_DATA -> all outputs 0 asynchronously, FSM in W_IDLE, pointer 0.
REQ-036 Four back-to-back reads with both masters requesting -> grants alternate m0, m1, m0, m1.
